operand_fetch_stage: RTL and testbench

Pipelined operand-fetch stage between instruction decode and execute. Extracts rd/rs1/rs2 indices from a 32-bit RV32I instruction and reads the register file through combinational read ports. Resolves RAW hazards by forwarding from `NUM_BYPASS` later pipeline stages, and stalls on load-use hazards. Delivers registered operands to execute over a valid/ready handshake, with a flush input.

---
 rtl/rv32i_pkg.sv | 44 ++++
 rtl/operand_bypass_mux.sv | 42 ++++
 rtl/operand_fetch_stage.sv | 131 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, register index type, bypass record and operand-usage decode.
package rv32i_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;

    typedef logic [REG_IDX_W-1:0] reg_index_t;
    typedef logic [6:0]           opcode_t;

    localparam opcode_t OPC_LOAD     = 7'b0000011;
    localparam opcode_t OPC_MISC_MEM = 7'b0001111;
    localparam opcode_t OPC_OP_IMM   = 7'b0010011;
    localparam opcode_t OPC_AUIPC    = 7'b0010111;
    localparam opcode_t OPC_STORE    = 7'b0100011;
    localparam opcode_t OPC_OP       = 7'b0110011;
    localparam opcode_t OPC_LUI      = 7'b0110111;
    localparam opcode_t OPC_BRANCH   = 7'b1100011;
    localparam opcode_t OPC_JALR     = 7'b1100111;
    localparam opcode_t OPC_JAL      = 7'b1101111;
    localparam opcode_t OPC_SYSTEM   = 7'b1110011;

    // One forwarding source as seen by operand fetch; execute and memory stages drive these.
    typedef struct packed {
        logic                    valid;
        reg_index_t              rd_index;
        logic                    data_ready;
        logic [XLEN_DEFAULT-1:0] data;
    } bypass_t;

    function automatic logic uses_rs1(input opcode_t opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: uses_rs1 = 1'b1;
            default:                                                      uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input opcode_t opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: x0, youngest matching bypass source, or register-file data.
module operand_bypass_mux
    import rv32i_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_BYPASS = 2
) (
    input  reg_index_t                     index_i,
    input  logic                           used_i,
    input  logic [XLEN-1:0]                rf_data_i,
    input  logic [NUM_BYPASS-1:0]          bp_valid_i,
    input  logic [NUM_BYPASS*REG_IDX_W-1:0] bp_rd_index_i,
    input  logic [NUM_BYPASS-1:0]          bp_data_ready_i,
    input  logic [NUM_BYPASS*XLEN-1:0]     bp_data_i,
    output logic [XLEN-1:0]                data_o,
    output logic                           stall_o
);

    logic found;
    logic win_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        data_o    = rf_data_i;
        found     = 1'b0;
        win_ready = 1'b1;
        if (index_i == '0) begin
            data_o = '0;
        end else begin
            // Ascending scan with a found flag: the first (youngest) match wins, older sources are ignored.
            for (int i = 0; i < NUM_BYPASS; i++) begin
                if (!found && bp_valid_i[i] && (bp_rd_index_i[i*REG_IDX_W +: REG_IDX_W] == index_i)) begin
                    found     = 1'b1;
                    data_o    = bp_data_i[i*XLEN +: XLEN];
                    win_ready = bp_data_ready_i[i];
                end
            end
        end
        stall_o = used_i && found && !win_ready;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register-file read, forwarding, load-use stall and a registered bundle toward execute.
module operand_fetch_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_BYPASS = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [31:0]                     in_instruction,
    input  logic [31:0]                     in_pc,
    output logic [4:0]                      rs1_read_index,
    output logic [4:0]                      rs2_read_index,
    input  logic [XLEN-1:0]                 rs1_read_data,
    input  logic [XLEN-1:0]                 rs2_read_data,
    input  logic [NUM_BYPASS-1:0]           bp_valid,
    input  logic [NUM_BYPASS*5-1:0]         bp_rd_index,
    input  logic [NUM_BYPASS-1:0]           bp_data_ready,
    input  logic [NUM_BYPASS*XLEN-1:0]      bp_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_pc,
    output logic [31:0]                     out_instruction,
    output logic [4:0]                      out_rd_index,
    output logic [XLEN-1:0]                 out_rs1_data,
    output logic [XLEN-1:0]                 out_rs2_data
);

    opcode_t         opcode;
    reg_index_t      rd_index;
    logic            rs1_used, rs2_used;
    logic [XLEN-1:0] rs1_res, rs2_res;
    logic            rs1_stall, rs2_stall;
    logic            hazard;
    logic            accept;

    logic            valid_q, valid_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    reg_index_t      rd_q, rd_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    assign opcode         = in_instruction[6:0];
    assign rd_index       = in_instruction[11:7];
    assign rs1_read_index = in_instruction[19:15];
    assign rs2_read_index = in_instruction[24:20];
    assign rs1_used       = uses_rs1(opcode);
    assign rs2_used       = uses_rs2(opcode);

    operand_bypass_mux #(.XLEN(XLEN), .NUM_BYPASS(NUM_BYPASS)) u_rs1_mux (
        .index_i         (rs1_read_index),
        .used_i          (rs1_used),
        .rf_data_i       (rs1_read_data),
        .bp_valid_i      (bp_valid),
        .bp_rd_index_i   (bp_rd_index),
        .bp_data_ready_i (bp_data_ready),
        .bp_data_i       (bp_data),
        .data_o          (rs1_res),
        .stall_o         (rs1_stall)
    );

    operand_bypass_mux #(.XLEN(XLEN), .NUM_BYPASS(NUM_BYPASS)) u_rs2_mux (
        .index_i         (rs2_read_index),
        .used_i          (rs2_used),
        .rf_data_i       (rs2_read_data),
        .bp_valid_i      (bp_valid),
        .bp_rd_index_i   (bp_rd_index),
        .bp_data_ready_i (bp_data_ready),
        .bp_data_i       (bp_data),
        .data_o          (rs2_res),
        .stall_o         (rs2_stall)
    );

    // Hazard depends only on the instruction and bypass state, never on in_valid.
    assign hazard   = rs1_stall || rs2_stall;
    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instruction;
            rd_d    = rd_index;
            rs1_d   = rs1_res;
            rs2_d   = rs2_res;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset too, because execute observes them as all-zero after reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_instruction = instr_q;
    assign out_rd_index    = rd_q;
    assign out_rs1_data    = rs1_q;
    assign out_rs2_data    = rs2_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage: forwarding, stalls, backpressure, flush, reset.
module tb_operand_fetch_stage;
    import rv32i_pkg::*;

    localparam int XLEN = 32;
    localparam int NB   = 2;

    localparam logic [31:0] ADD_X3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] ADD_X6  = 32'h00208333; // add  x6,x1,x2
    localparam logic [31:0] ADDI_X5 = 32'h00100293; // addi x5,x0,1 (rs2 field = 1, unused)
    localparam logic [31:0] LUI_X7  = 32'h000103B7; // lui  x7,0x10 (rs1 field = 2, unused)
    localparam logic [31:0] SW_X2   = 32'h0020A023; // sw   x2,0(x1)

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       in_instruction, in_pc, out_pc, out_instruction;
    logic [4:0]        rs1_read_index, rs2_read_index, out_rd_index;
    logic [XLEN-1:0]   rs1_read_data, rs2_read_data, out_rs1_data, out_rs2_data;
    logic [NB-1:0]     bp_valid, bp_data_ready;
    logic [NB*5-1:0]   bp_rd_index;
    logic [NB*XLEN-1:0] bp_data;
    logic [XLEN-1:0]   rf [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rs1_read_data = rf[rs1_read_index];
    assign rs2_read_data = rf[rs2_read_index];

    operand_fetch_stage #(.XLEN(XLEN), .NUM_BYPASS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .rs1_read_index(rs1_read_index), .rs2_read_index(rs2_read_index),
        .rs1_read_data(rs1_read_data), .rs2_read_data(rs2_read_data),
        .bp_valid(bp_valid), .bp_rd_index(bp_rd_index),
        .bp_data_ready(bp_data_ready), .bp_data(bp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction), .out_rd_index(out_rd_index),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
    );

    task automatic set_bp(input int i, input bypass_t b);
        bp_valid[i]           = b.valid;
        bp_rd_index[i*5 +: 5] = b.rd_index;
        bp_data_ready[i]      = b.data_ready;
        bp_data[i*XLEN +: XLEN] = b.data;
    endtask

    task automatic clear_bp();
        bp_valid = '0; bp_rd_index = '0; bp_data_ready = '0; bp_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instruction = ADD_X3; in_pc = 32'h0; clear_bp();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0 ||
            out_rd_index !== 5'd0 || out_rs1_data !== '0 || out_rs2_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h instr=%h rd=%0d rs1=%h rs2=%h, required all 0",
                     out_valid, out_pc, out_instruction, out_rd_index, out_rs1_data, out_rs2_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_instruction = ADD_X3; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1; clear_bp();
        #1;
        checks++;
        if (rs1_read_index !== 5'd1 || rs2_read_index !== 5'd2) begin
            errors++; $display("FAIL read_index: rs1=%0d rs2=%0d, required 1 2", rs1_read_index, rs2_read_index);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rs1_data !== 32'd5 || out_rs2_data !== 32'd7 ||
            out_rd_index !== 5'd3 || out_pc !== 32'h100 || out_instruction !== ADD_X3) begin
            errors++;
            $display("FAIL basic_add: valid=%b rs1=%h rs2=%h rd=%0d pc=%h, required 1 5 7 3 100",
                     out_valid, out_rs1_data, out_rs2_data, out_rd_index, out_pc);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_priority();
        // Both sources write x1: the youngest (bp0) wins, rs2 comes from the register file.
        @(negedge clk);
        in_instruction = ADD_X3; in_pc = 32'h200; in_valid = 1'b1;
        set_bp(0, '{1'b1, 5'd1, 1'b1, 32'hAA});
        set_bp(1, '{1'b1, 5'd1, 1'b1, 32'hBB});
        @(negedge clk);
        checks++;
        if (out_rs1_data !== 32'hAA || out_rs2_data !== 32'd7) begin
            errors++; $display("FAIL prio_same_rd: rs1=%h rs2=%h, required aa 7", out_rs1_data, out_rs2_data);
        end
        set_bp(1, '{1'b1, 5'd2, 1'b1, 32'hCC});
        in_pc = 32'h204;
        @(negedge clk);
        checks++;
        if (out_rs1_data !== 32'hAA || out_rs2_data !== 32'hCC || out_pc !== 32'h204) begin
            errors++; $display("FAIL prio_split: rs1=%h rs2=%h pc=%h, required aa cc 204", out_rs1_data, out_rs2_data, out_pc);
        end
        // bp0 wins and is ready, so the not-ready older source must not stall.
        set_bp(0, '{1'b1, 5'd1, 1'b1, 32'h11});
        set_bp(1, '{1'b1, 5'd1, 1'b0, 32'h22});
        in_pc = 32'h208;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL prio_shadow_stall: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; clear_bp();
        checks++;
        if (out_rs1_data !== 32'h11) begin
            errors++; $display("FAIL prio_shadow_data: rs1=%h, required 11", out_rs1_data);
        end
    endtask

    task automatic test_unused_and_x0();
        @(negedge clk);
        in_instruction = ADDI_X5; in_pc = 32'h300; in_valid = 1'b1;
        set_bp(0, '{1'b1, 5'd0, 1'b0, 32'hFF});
        set_bp(1, '{1'b1, 5'd1, 1'b0, 32'hEE});
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL x0_no_stall: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rs1_data !== 32'd0 || out_rd_index !== 5'd5) begin
            errors++; $display("FAIL x0_data: valid=%b rs1=%h rd=%0d, required 1 0 5", out_valid, out_rs1_data, out_rd_index);
        end
        in_instruction = LUI_X7; in_pc = 32'h304;
        set_bp(0, '{1'b1, 5'd2, 1'b0, 32'h0});
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL lui_no_stall: in_ready=%b, required 1", in_ready);
        end
        in_instruction = SW_X2; in_pc = 32'h308;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL store_rs2_stall: in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; clear_bp();
        @(negedge clk);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        in_instruction = ADDI_X5; in_pc = 32'h400; in_valid = 1'b1; out_ready = 1'b1; clear_bp();
        @(negedge clk);
        in_instruction = ADD_X3; in_pc = 32'h404;
        set_bp(0, '{1'b1, 5'd2, 1'b0, 32'h0});
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 || in_ready !== 1'b0) begin
            errors++; $display("FAIL lu_first: valid=%b pc=%h in_ready=%b, required 1 400 0", out_valid, out_pc, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        set_bp(0, '{1'b1, 5'd2, 1'b1, 32'h10});
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_release: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; clear_bp();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h404 || out_rs1_data !== 32'd5 || out_rs2_data !== 32'h10) begin
            errors++; $display("FAIL lu_result: valid=%b pc=%h rs1=%h rs2=%h, required 1 404 5 10",
                               out_valid, out_pc, out_rs1_data, out_rs2_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h500; pcs[1] = 32'h504; pcs[2] = 32'h508;
        @(negedge clk);
        out_ready = 1'b1; in_instruction = ADD_X3; in_valid = 1'b1; in_pc = pcs[0];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) in_pc = pcs[k]; else in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[k-1]) begin
                errors++; $display("FAIL b2b_%0d: valid=%b pc=%h, required 1 %h", k, out_valid, out_pc, pcs[k-1]);
            end
        end
    endtask

    task automatic test_hold_flush();
        @(negedge clk);
        in_instruction = ADD_X3; in_pc = 32'h600; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_instruction = ADD_X6; in_pc = 32'h610;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_rd_index !== 5'd3 ||
                out_rs1_data !== 32'd5 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: valid=%b pc=%h rd=%0d rs1=%h in_ready=%b, required 1 600 3 5 0",
                                   k, out_valid, out_pc, out_rd_index, out_rs1_data, in_ready);
            end
            @(negedge clk);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_pc === 32'h610) begin
            errors++; $display("FAIL flush: valid=%b pc=%h, required valid 0 and pc not 610", out_valid, out_pc);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_instruction = ADD_X3; in_pc = 32'h700; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: valid=%b, required 1", out_valid);
        end
        rst_n = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0 ||
            out_rd_index !== 5'd0 || out_rs1_data !== '0 || out_rs2_data !== '0) begin
            errors++; $display("FAIL rstmid_outputs: valid=%b pc=%h instr=%h rd=%0d rs1=%h rs2=%h, required all 0",
                               out_valid, out_pc, out_instruction, out_rd_index, out_rs1_data, out_rs2_data);
        end
        rst_n = 1'b1; in_valid = 1'b0; clear_bp();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'h100 + r;
        rf[0] = '0; rf[1] = 32'd5; rf[2] = 32'd7;
        test_reset();
        test_basic();
        test_priority();
        test_unused_and_x0();
        test_load_use();
        test_back_to_back();
        test_hold_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
